// File: rtl/aes_pkg.sv
// Shared AES definitions: widths, GF(2^8) helpers, InvMixColumns coefficients
// and the sequential-unit FSM state type.
package aes_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned COL_W     = 32;
  localparam int unsigned STATE_W   = 128;
  localparam int unsigned COL_IDX_W = 2;

  localparam logic [BYTE_W-1:0] INV_C_E = 8'h0e;
  localparam logic [BYTE_W-1:0] INV_C_B = 8'h0b;
  localparam logic [BYTE_W-1:0] INV_C_D = 8'h0d;
  localparam logic [BYTE_W-1:0] INV_C_9 = 8'h09;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Multiply by x modulo x^8+x^4+x^3+x+1.
  function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Constant multiply for the coefficients used by MixColumns and its inverse.
  function automatic logic [BYTE_W-1:0] gf_mul(input logic [BYTE_W-1:0] a,
                                               input logic [BYTE_W-1:0] c);
    logic [BYTE_W-1:0] x2;
    logic [BYTE_W-1:0] x4;
    logic [BYTE_W-1:0] x8;
    logic [BYTE_W-1:0] r;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    case (c)
      8'h02:   r = x2;
      8'h03:   r = x2 ^ a;
      8'h09:   r = x8 ^ a;
      8'h0b:   r = x8 ^ x2 ^ a;
      8'h0d:   r = x8 ^ x4 ^ a;
      8'h0e:   r = x8 ^ x4 ^ x2;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/inv_mixcolumn_col.sv
// Combinational InvMixColumns on a single 32-bit column (top byte = row 0).
module inv_mixcolumn_col
  import aes_pkg::*;
(
  input  logic [COL_W-1:0] col_i,
  output logic [COL_W-1:0] col_o
);

  logic [BYTE_W-1:0] a0, a1, a2, a3;
  logic [BYTE_W-1:0] b0, b1, b2, b3;

  assign a0 = col_i[31:24];
  assign a1 = col_i[23:16];
  assign a2 = col_i[15:8];
  assign a3 = col_i[7:0];

  assign b0 = gf_mul(a0, INV_C_E) ^ gf_mul(a1, INV_C_B) ^ gf_mul(a2, INV_C_D) ^ gf_mul(a3, INV_C_9);
  assign b1 = gf_mul(a0, INV_C_9) ^ gf_mul(a1, INV_C_E) ^ gf_mul(a2, INV_C_B) ^ gf_mul(a3, INV_C_D);
  assign b2 = gf_mul(a0, INV_C_D) ^ gf_mul(a1, INV_C_9) ^ gf_mul(a2, INV_C_E) ^ gf_mul(a3, INV_C_B);
  assign b3 = gf_mul(a0, INV_C_B) ^ gf_mul(a1, INV_C_D) ^ gf_mul(a2, INV_C_9) ^ gf_mul(a3, INV_C_E);

  assign col_o = {b0, b1, b2, b3};

endmodule

// File: rtl/inv_mixcolumn_seq.sv
// Sequential InvMixColumns: accepts a 128-bit state, transforms one column per
// clock through a shared column multiplier, then holds the result for output.
module inv_mixcolumn_seq
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_data
);

  localparam logic [COL_IDX_W-1:0] LAST_COL = COL_IDX_W'(3);

  state_e               state_q, state_d;
  logic [COL_IDX_W-1:0] col_q, col_d;
  logic [STATE_W-1:0]   data_q, data_d;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic [COL_W-1:0]     col_sel_c;
  logic [COL_W-1:0]     col_res_c;

  // Select the column currently being transformed.
  always_comb begin
    col_sel_c = data_q[127:96];
    case (col_q)
      2'd0: col_sel_c = data_q[127:96];
      2'd1: col_sel_c = data_q[95:64];
      2'd2: col_sel_c = data_q[63:32];
      2'd3: col_sel_c = data_q[31:0];
    endcase
  end

  inv_mixcolumn_col u_col (
    .col_i (col_sel_c),
    .col_o (col_res_c)
  );

  // Next-state, column counter and state-register update.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          data_d  = in_data;
          col_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        case (col_q)
          2'd0: data_d[127:96] = col_res_c;
          2'd1: data_d[95:64]  = col_res_c;
          2'd2: data_d[63:32]  = col_res_c;
          2'd3: data_d[31:0]   = col_res_c;
        endcase
        col_d = col_q + COL_IDX_W'(1);
        if (col_q == LAST_COL) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake flags are registered copies of the next FSM state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      col_q       <= '0;
      data_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      data_q      <= data_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = data_q;

endmodule

// File: tb/tb_inv_mixcolumn_seq.sv
// Randomized self-checking bench for inv_mixcolumn_seq against a matrix-level
// GF(2^8) reference model.
module tb_inv_mixcolumn_seq;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int out_cnt = 0;
  logic [127:0] exp_q[$];
  int acc_q[$];
  int acc_log[$];
  logic prev_ov = 1'b0;

  inv_mixcolumn_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Carry-less product followed by polynomial long division by 0x11b.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  // Circulant matrix product per column; inv selects InvMixColumns or MixColumns.
  function automatic logic [127:0] mat(input logic [127:0] s, input bit inv);
    logic [7:0] base[4];
    logic [127:0] o;
    logic [7:0] acc;
    if (inv) base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     base = '{8'h02, 8'h03, 8'h01, 8'h01};
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = '0;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gmul(s[127 - 32*c - 8*k -: 8], base[(k - r + 4) % 4]);
        o[127 - 32*c - 8*r -: 8] = acc;
      end
    return o;
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    tests++;
    fails++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Compare process: every cycle out_valid is high, out_data must match the model.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      acc_q.delete();
      prev_ov = 1'b0;
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) flag("unexpected_out_valid");
        else chk("out_data", out_data, exp_q[0]);
        if (!prev_ov && acc_q.size() != 0) chk("latency", 128'(cyc - acc_q.pop_front()), 128'd4);
        if (out_ready && exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          out_cnt++;
        end
      end
      if (in_ready && out_valid) flag("ready_and_valid_both_high");
      if (in_valid && in_ready) begin
        exp_q.push_back(mat(in_data, 1'b1));
        acc_q.push_back(cyc + 1);
        acc_log.push_back(cyc + 1);
      end
      prev_ov = out_valid;
    end
  end

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic send(input logic [127:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 100) begin
        flag("accept_timeout");
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_ov();
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) flag("out_valid_timeout");
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && !out_valid && in_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) flag("idle_timeout");
    @(posedge clk); #1;
  endtask

  task automatic xfer_lit(input string name, input logic [127:0] din, input logic [127:0] dexp);
    chk({name, "_model"}, mat(din, 1'b1), dexp);
    out_ready = 1'b0;
    send(din);
    in_valid = 1'b0;
    wait_ov();
    chk(name, out_data, dexp);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    wait_idle();
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] s, m, held;
    int n0, c0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'd0);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_out_data", out_data, 128'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 128'(in_ready), 128'd1);

    // Hand-computed vectors.
    xfer_lit("vec_single_col", 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6,
                               128'hdb135345_f20a225c_01010101_c6c6c6c6);
    xfer_lit("vec_reduction",  128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff,
                               128'hd4d4d4d5_2d26314c_00000000_ffffffff);

    // Back-pressure in DONE with in_data/in_valid toggling.
    out_ready = 1'b0;
    c0 = out_cnt;
    send({$urandom, $urandom, $urandom, $urandom});
    in_valid = 1'b0;
    wait_ov();
    held = out_data;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'($urandom);
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
      chk("bp_out_valid", 128'(out_valid), 128'd1);
      chk("bp_out_data_stable", out_data, held);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("bp_released", 128'(out_valid), 128'd0);
    wait_idle();
    chk("bp_single_transfer", 128'(out_cnt - c0), 128'd1);

    // Back-to-back with in_valid and out_ready held high.
    out_ready = 1'b1;
    n0 = acc_log.size();
    c0 = out_cnt;
    send({$urandom, $urandom, $urandom, $urandom});
    send({$urandom, $urandom, $urandom, $urandom});
    in_valid = 1'b0;
    wait_idle();
    if (acc_log.size() == n0 + 2) chk("b2b_spacing", 128'(acc_log[n0+1] - acc_log[n0]), 128'd6);
    else flag("b2b_accept_count");
    chk("b2b_transfers", 128'(out_cnt - c0), 128'd2);

    // Reset two edges after accept aborts the transform.
    c0 = out_cnt;
    send({$urandom, $urandom, $urandom, $urandom});
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("abort_out_valid", 128'(out_valid), 128'd0);
    chk("abort_out_data", out_data, 128'd0);
    chk("abort_in_ready", 128'(in_ready), 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_in_ready_after", 128'(in_ready), 128'd1);
    chk("abort_no_output", 128'(out_cnt - c0), 128'd0);
    send(128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6);
    in_valid = 1'b0;
    wait_ov();
    chk("abort_next_state", out_data, 128'hdb135345_f20a225c_01010101_c6c6c6c6);
    wait_idle();

    // Round trip: MixColumns then this unit recovers the original state.
    for (int i = 0; i < 1000; i++) begin
      s = {$urandom, $urandom, $urandom, $urandom};
      m = mat(s, 1'b0);
      chk("roundtrip_model", mat(m, 1'b1), s);
      send(m);
      in_valid = 1'b0;
      if (i % 4 == 0) begin
        out_ready = 1'b0;
        repeat ($urandom_range(1, 8)) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end else if (i % 7 == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    out_ready = 1'b1;
    wait_idle();
    chk("queue_drained", 128'(exp_q.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
